// File: rtl/mcu_if_pkg.sv
// Shared definitions for the MCU register-strobe controller.
// Holds the controller state encoding and the default parameter values.
package mcu_if_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    DONE   = 2'd2
  } rs_state_e;

  localparam int NUM_REGS_DEF    = 31;
  localparam int ADDR_W_DEF      = 5;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int TIMEOUT_CYC_DEF = 255;

endpackage

// File: rtl/mcu_sync_bit.sv
// Single-bit flop-chain synchroniser with asynchronous active-high reset.
// STAGES = 0 turns the block into a plain wire.
module mcu_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic i_sys_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  genvar gi;

  generate
    if (STAGES == 0) begin : g_bypass
      assign o_q = i_d;
    end else begin : g_chain
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
        logic q_reg;
        if (gi == 0) begin : g_first
          // first flop samples the asynchronous input
          always_ff @(posedge i_sys_clk or posedge i_reset) begin
            if (i_reset) q_reg <= 1'b0;
            else         q_reg <= i_d;
          end
        end else begin : g_next
          // later flops settle any metastability from the previous stage
          always_ff @(posedge i_sys_clk or posedge i_reset) begin
            if (i_reset) q_reg <= 1'b0;
            else         q_reg <= g_stage[gi-1].q_reg;
          end
        end
      end
      assign o_q = g_stage[STAGES-1].q_reg;
    end
  endgenerate

endmodule

// File: rtl/mcu_rs_strobe_ctrl.sv
// MCU register-strobe controller: turns an asynchronous chip-select access
// into a single-cycle one-hot read or write strobe, with acknowledge,
// DONE-state timeout and optional sticky out-of-range address flag.
// Optional feature macro: RS_ADDR_ERR_EN (enables the o_addr_err flop).
module mcu_rs_strobe_ctrl
  import mcu_if_pkg::*;
#(
  parameter int NUM_REGS    = NUM_REGS_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                i_sys_clk,
  input  logic                i_reset,
  input  logic                i_cs,
  input  logic                i_r_neg_w,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [NUM_REGS-1:0] o_rd_vec,
  output logic [NUM_REGS-1:0] o_wr_vec,
  output logic                o_ack,
  output logic                o_busy,
  output logic                o_timeout,
  output logic                o_addr_err
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  if ((2 ** ADDR_W) < NUM_REGS) begin : g_addr_w_check
    $error("ADDR_W too narrow to address NUM_REGS registers");
  end
  if ((SYNC_STAGES < 0) || (SYNC_STAGES > 3)) begin : g_sync_check
    $error("SYNC_STAGES must be in 0..3");
  end

  genvar gi;

  logic              cs_s;
  logic              rnw_s;
  rs_state_e         state_reg;
  logic [ADDR_W-1:0] addr_q;
  logic              dir_q;
  logic [CNT_W-1:0]  cnt_reg;
  logic              wait_low_reg;
  logic              timeout_reg;
  logic              start_access;
  logic [NUM_REGS-1:0] sel_vec;

  mcu_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .i_sys_clk (i_sys_clk),
    .i_reset   (i_reset),
    .i_d       (i_cs),
    .o_q       (cs_s)
  );

  mcu_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_rnw (
    .i_sys_clk (i_sys_clk),
    .i_reset   (i_reset),
    .i_d       (i_r_neg_w),
    .o_q       (rnw_s)
  );

  // a new access begins from IDLE (once re-armed) or on a direction change in DONE
  assign start_access = cs_s &&
                        (((state_reg == IDLE) && !wait_low_reg) ||
                         ((state_reg == DONE) && (rnw_s != dir_q)));

  // controller FSM with address/direction capture and DONE timeout
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg    <= IDLE;
      addr_q       <= '0;
      dir_q        <= 1'b0;
      cnt_reg      <= '0;
      wait_low_reg <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (!cs_s) wait_low_reg <= 1'b0;
          if (start_access) begin
            state_reg <= STROBE;
            addr_q    <= i_addr;
            dir_q     <= rnw_s;
          end
        end
        STROBE: begin
          state_reg <= DONE;
          cnt_reg   <= '0;
        end
        DONE: begin
          if (!cs_s) begin
            state_reg <= IDLE;
          end else if (start_access) begin
            state_reg <= STROBE;
            addr_q    <= i_addr;
            dir_q     <= rnw_s;
          end else if ((TIMEOUT_CYC != 0) && (cnt_reg == CNT_LAST)) begin
            state_reg    <= IDLE;
            timeout_reg  <= 1'b1;
            wait_low_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // one-hot decode of the captured address; out-of-range decodes to zero
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_dec
      assign sel_vec[gi] = (addr_q == ADDR_W'(gi));
    end
  endgenerate

  assign o_rd_vec  = ((state_reg == STROBE) &&  dir_q) ? sel_vec : '0;
  assign o_wr_vec  = ((state_reg == STROBE) && !dir_q) ? sel_vec : '0;
  assign o_ack     = (state_reg == DONE);
  assign o_busy    = (state_reg != IDLE);
  assign o_timeout = timeout_reg;

`ifdef RS_ADDR_ERR_EN
  logic addr_err_reg;

  // sticky flag: set when an access starts on an address with no register
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      addr_err_reg <= 1'b0;
    end else if (start_access && (int'(i_addr) >= NUM_REGS)) begin
      addr_err_reg <= 1'b1;
    end
  end

  assign o_addr_err = addr_err_reg;
`else
  assign o_addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_mcu_rs_strobe_ctrl.sv
// Testbench for mcu_rs_strobe_ctrl: table-driven cycle vectors plus
// hand-written timeout, reset-mid-strobe and random protocol sequences.
module tb_mcu_rs_strobe_ctrl;

  localparam int NR = 31;
  localparam int AW = 5;
`ifdef RS_ADDR_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cs  = 1'b0;
  logic          rnw = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [NR-1:0] rd_vec;
  logic [NR-1:0] wr_vec;
  logic          ack;
  logic          busy;
  logic          tmo;
  logic          aerr;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mcu_rs_strobe_ctrl #(
    .NUM_REGS    (NR),
    .ADDR_W      (AW),
    .SYNC_STAGES (2),
    .TIMEOUT_CYC (8)
  ) dut (
    .i_sys_clk  (clk),
    .i_reset    (rst),
    .i_cs       (cs),
    .i_r_neg_w  (rnw),
    .i_addr     (addr),
    .o_rd_vec   (rd_vec),
    .o_wr_vec   (wr_vec),
    .o_ack      (ack),
    .o_busy     (busy),
    .o_timeout  (tmo),
    .o_addr_err (aerr)
  );

  typedef struct {
    bit          cs;
    bit          rnw;
    int          addr;
    logic [30:0] rd;
    logic [30:0] wr;
    bit          ack;
    bit          busy;
    bit          tmo;
    bit          err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit c, bit r, int a, logic [30:0] erd,
                              logic [30:0] ewr, bit eack, bit ebusy,
                              bit etmo, bit eerr);
    vec_t v;
    v.cs = c; v.rnw = r; v.addr = a; v.rd = erd; v.wr = ewr;
    v.ack = eack; v.busy = ebusy; v.tmo = etmo; v.err = eerr;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [30:0] erd,
                           input logic [30:0] ewr, input bit eack,
                           input bit ebusy, input bit etmo, input bit eerr);
    check({tag, ".rd"},   64'(rd_vec), 64'(erd));
    check({tag, ".wr"},   64'(wr_vec), 64'(ewr));
    check({tag, ".ack"},  64'(ack),    64'(eack));
    check({tag, ".busy"}, 64'(busy),   64'(ebusy));
    check({tag, ".tmo"},  64'(tmo),    64'(etmo));
    check({tag, ".err"},  64'(aerr),   64'(eerr));
  endtask

  localparam logic [30:0] R5  = 31'h0000_0020;
  localparam logic [30:0] B30 = 31'h4000_0000;
  localparam logic [30:0] B3  = 31'h0000_0008;
  localparam logic [30:0] B7  = 31'h0000_0080;
  localparam logic [30:0] Z   = 31'h0;

  initial begin
    int viol;
    bit e;
    e = ERR_EN;

    // reset state
    #2;
    check_all("reset", Z, Z, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_all("post_reset", Z, Z, 0, 0, 0, 0);

    // read addr 5
    vecs.push_back(mk(1,1,5, Z,Z, 0,0,0,0));
    vecs.push_back(mk(1,1,5, Z,Z, 0,0,0,0));
    vecs.push_back(mk(1,1,5, R5,Z, 0,1,0,0));
    vecs.push_back(mk(1,1,5, Z,Z, 1,1,0,0));
    vecs.push_back(mk(1,1,5, Z,Z, 1,1,0,0));
    vecs.push_back(mk(0,1,5, Z,Z, 1,1,0,0));
    vecs.push_back(mk(0,1,5, Z,Z, 1,1,0,0));
    vecs.push_back(mk(0,1,5, Z,Z, 0,0,0,0));
    vecs.push_back(mk(0,1,5, Z,Z, 0,0,0,0));
    // write addr 30, then rnw 0->1 with cs held: back-to-back read
    vecs.push_back(mk(1,0,30, Z,Z, 0,0,0,0));
    vecs.push_back(mk(1,0,30, Z,Z, 0,0,0,0));
    vecs.push_back(mk(1,0,30, Z,B30, 0,1,0,0));
    vecs.push_back(mk(1,1,30, Z,Z, 1,1,0,0));
    vecs.push_back(mk(1,1,30, Z,Z, 1,1,0,0));
    vecs.push_back(mk(1,1,30, B30,Z, 0,1,0,0));
    vecs.push_back(mk(1,1,30, Z,Z, 1,1,0,0));
    vecs.push_back(mk(0,1,30, Z,Z, 1,1,0,0));
    vecs.push_back(mk(0,1,30, Z,Z, 1,1,0,0));
    vecs.push_back(mk(0,1,30, Z,Z, 0,0,0,0));
    vecs.push_back(mk(0,1,30, Z,Z, 0,0,0,0));
    // out-of-range address 31
    vecs.push_back(mk(1,1,31, Z,Z, 0,0,0,0));
    vecs.push_back(mk(1,1,31, Z,Z, 0,0,0,0));
    vecs.push_back(mk(1,1,31, Z,Z, 0,1,0,e));
    vecs.push_back(mk(1,1,31, Z,Z, 1,1,0,e));
    vecs.push_back(mk(0,1,31, Z,Z, 1,1,0,e));
    vecs.push_back(mk(0,1,31, Z,Z, 1,1,0,e));
    vecs.push_back(mk(0,1,31, Z,Z, 0,0,0,e));
    vecs.push_back(mk(0,1,31, Z,Z, 0,0,0,e));

    foreach (vecs[i]) begin
      cs   = vecs[i].cs;
      rnw  = vecs[i].rnw;
      addr = AW'(vecs[i].addr);
      tick();
      $display("vec %0d cs=%0b rnw=%0b addr=%0d rd=%h wr=%h ack=%0b busy=%0b",
               i, cs, rnw, addr, rd_vec, wr_vec, ack, busy);
      check_all($sformatf("v%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].ack,
                vecs[i].busy, vecs[i].tmo, vecs[i].err);
    end

    // reset clears the sticky error flag
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("err_cleared", 64'(aerr), 64'(0));

    // timeout: cs held 20 cycles, read addr 3
    cs = 1'b1; rnw = 1'b1; addr = 5'd3;
    tick();
    tick();
    tick();
    check("to.strobe", 64'(rd_vec), 64'(B3));
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("to.done%0d.ack", k), 64'(ack), 64'(1));
      check($sformatf("to.done%0d.tmo", k), 64'(tmo), 64'(0));
    end
    tick();
    $display("timeout cycle tmo=%0b busy=%0b ack=%0b", tmo, busy, ack);
    check_all("to.fire", Z, Z, 0, 0, 1, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check_all($sformatf("to.hold%0d", k), Z, Z, 0, 0, 0, 0);
    end
    cs = 1'b0;
    tick();
    tick();
    tick();
    cs = 1'b1;
    tick();
    tick();
    check("to.rearm_idle", 64'(busy), 64'(0));
    tick();
    $display("rearm rd=%h busy=%0b", rd_vec, busy);
    check("to.rearm_strobe", 64'(rd_vec), 64'(B3));
    cs = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("to.back_idle", 64'(busy), 64'(0));

    // reset asserted mid-STROBE
    cs = 1'b1; rnw = 1'b0; addr = 5'd7;
    tick();
    tick();
    tick();
    check("rst.strobe", 64'(wr_vec), 64'(B7));
    rst = 1'b1;
    cs  = 1'b0;
    #1;
    check_all("rst.immediate", Z, Z, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      $display("after reset %0d wr=%h rd=%h busy=%0b", k, wr_vec, rd_vec, busy);
      check_all($sformatf("rst.after%0d", k), Z, Z, 0, 0, 0, 0);
    end

    // random protocol traffic: one-hot and busy consistency
    viol = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(7) == 0) cs = ~cs;
      if ($urandom_range(3) == 0) rnw = ~rnw;
      if (!cs) addr = AW'($urandom_range(31));
      tick();
      if ($countones({rd_vec, wr_vec}) > 1) viol++;
      if (!busy && ((|rd_vec) || (|wr_vec) || ack)) viol++;
      if (((|rd_vec) || (|wr_vec)) && ack) viol++;
    end
    $display("random phase violations=%0d", viol);
    check("rand.violations", 64'(viol), 64'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
